// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: sequencer states, default PC width, reset vector.
package cpu_pkg;

    localparam int PC_W_DEF = 6;
    localparam int PC_RESET = 0;

    typedef enum logic [1:0] {
        PS_FLUSH = 2'd0,
        PS_RUN   = 2'd1,
        PS_HALT  = 2'd2
    } pc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// One cycle from inc_i to cnt_o; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: advances, holds, redirects or freezes the fetch PC and drives pipeline bubbles.
// Redirect lands one edge after br_taken; stall_req holds the PC for as long as it is asserted.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pcout,
    output logic             if_valid,
    output logic             pc_hold,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0]      FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_RST     = PC_W'(PC_RESET);

    pc_state_e       state_q;
    logic [PC_W-1:0] pc_q;
    logic            if_valid_q;
    logic            halted_q;
    logic [3:0]      fcnt_q;
    logic            stall_inc;

    // Controls default to "bubble everything"; RUN relaxes them per request.
    always_comb begin
        pc_hold    = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        stall_inc  = 1'b0;
        case (state_q)
            PS_RUN: begin
                if (br_taken) begin
                    pc_hold = 1'b0;
                end else if (halt_req) begin
                    flush_idex = 1'b0;
                end else if (stall_req) begin
                    flush_ifid = 1'b0;
                    stall_inc  = 1'b1;
                end else begin
                    pc_hold    = 1'b0;
                    flush_ifid = 1'b0;
                    flush_idex = 1'b0;
                end
            end
            PS_HALT: flush_idex = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PS_FLUSH;
            pc_q       <= PC_RST;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            case (state_q)
                PS_FLUSH: begin
                    fcnt_q <= fcnt_q + 1'b1;
                    if (fcnt_q == FLUSH_LAST) begin
                        state_q    <= PS_RUN;
                        if_valid_q <= 1'b1;
                    end
                end
                PS_RUN: begin
                    if (br_taken) begin
                        pc_q       <= br_target;
                        if_valid_q <= 1'b1;
                    end else if (halt_req) begin
                        state_q    <= PS_HALT;
                        halted_q   <= 1'b1;
                        if_valid_q <= 1'b0;
                    end else if (!stall_req) begin
                        pc_q       <= pc_q + 1'b1;
                        if_valid_q <= 1'b1;
                    end
                end
                PS_HALT: ;
                default: state_q <= PS_FLUSH;
            endcase
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );

    assign pcout    = pc_q;
    assign if_valid = if_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a phase-level reference model.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall_req = 1'b0;
    logic       br_taken = 1'b0;
    logic       halt_req = 1'b0;
    logic [5:0] br_target = '0;
    logic [5:0] pcout;
    logic       if_valid, pc_hold, flush_ifid, flush_idex, halted;
    logic [3:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = flushing, 1 = running, 2 = halted
    int m_phase, m_left, m_pc, m_cnt;
    bit m_valid, m_halted;

    pc_sequencer #(.PC_W(6), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .br_taken(br_taken),
        .br_target(br_target), .halt_req(halt_req), .pcout(pcout), .if_valid(if_valid),
        .pc_hold(pc_hold), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_comb();
        if (m_phase == 2) return 3'b110;
        if (m_phase == 0) return 3'b111;
        if (br_taken)  return 3'b011;
        if (halt_req)  return 3'b110;
        if (stall_req) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic [11:0] exp_regs();
        return {6'(m_pc), m_valid, m_halted, 4'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 2; m_pc = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
    endtask

    // Called just after a falling edge; leaves time 1 unit later for sampling.
    task automatic drive(input logic s, input logic b, input logic h, input logic [5:0] t);
        stall_req = s; br_taken = b; halt_req = h; br_target = t;
        #1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        if (!reset) begin
            case (m_phase)
                0: if (m_left == 1) begin m_phase = 1; m_valid = 1; end else m_left--;
                1: begin
                    if (br_taken) begin m_pc = int'(br_target); m_valid = 1; end
                    else if (halt_req) begin m_phase = 2; m_halted = 1; m_valid = 0; end
                    else if (stall_req) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
                    else begin m_pc = (m_pc + 1) % 64; m_valid = 1; end
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 6'd0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to(input int target);
        int k;
        for (k = 0; k < 200 && m_pc != target; k++) begin
            drive(0, 0, 0, 6'd0);
            clk_edge();
        end
        checks++;
        if (m_pc != target) begin
            errors++;
            $display("FAIL run_to: model pc %0d, required %0d", m_pc, target);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({pcout, if_valid, halted, stall_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h, required 000", {pcout, if_valid, halted, stall_cnt});
        end
        checks++;
        if ({pc_hold, flush_ifid, flush_idex} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 111", {pc_hold, flush_ifid, flush_idex});
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_flush_release();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 6'd0);
            checks++;
            if ({pcout, if_valid} !== {6'((i < 2) ? 0 : i - 2), i >= 2}) begin
                errors++;
                $display("FAIL flush_release[%0d]: pc=%0d vld=%b, required pc=%0d vld=%b",
                         i, pcout, if_valid, (i < 2) ? 0 : i - 2, i >= 2);
            end
            checks++;
            if ({pc_hold, flush_ifid, flush_idex} !== exp_comb()) begin
                errors++;
                $display("FAIL flush_ctrl[%0d]: got %b, required %b", i,
                         {pc_hold, flush_ifid, flush_idex}, exp_comb());
            end
            clk_edge();
        end
    endtask

    task automatic test_wrap();
        run_to(62);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 6'd0);
            checks++;
            if ({pcout, if_valid, pc_hold, flush_ifid, flush_idex} !== {6'((62 + i) % 64), 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL wrap[%0d]: pc=%0d vld=%b ctrl=%b, required pc=%0d vld=1 ctrl=000",
                         i, pcout, if_valid, {pc_hold, flush_ifid, flush_idex}, (62 + i) % 64);
            end
            clk_edge();
        end
    endtask

    task automatic test_stall();
        reset_dut();
        run_to(5);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 6'd0);
            checks++;
            if ({pcout, pc_hold, flush_idex, flush_ifid} !== {6'd5, 3'b110}) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%0d ctrl(hold,idex,ifid)=%b, required pc=5 ctrl=110",
                         i, pcout, {pc_hold, flush_idex, flush_ifid});
            end
            clk_edge();
        end
        drive(0, 0, 0, 6'd0);
        checks++;
        if ({pcout, stall_cnt} !== {6'd5, 4'd3}) begin
            errors++;
            $display("FAIL stall_end: pc=%0d cnt=%0d, required pc=5 cnt=3", pcout, stall_cnt);
        end
        clk_edge();
        drive(0, 0, 0, 6'd0);
        checks++;
        if (pcout !== 6'd6) begin
            errors++;
            $display("FAIL stall_resume: pc=%0d, required 6", pcout);
        end
        clk_edge();
    endtask

    task automatic test_branch_priority();
        run_to(9);
        drive(1, 1, 1, 6'h2A);
        checks++;
        if ({pc_hold, flush_ifid, flush_idex} !== 3'b011) begin
            errors++;
            $display("FAIL branch_ctrl: got %b, required 011", {pc_hold, flush_ifid, flush_idex});
        end
        clk_edge();
        drive(0, 0, 0, 6'd0);
        checks++;
        if ({pcout, if_valid, halted, stall_cnt} !== {6'h2A, 1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL branch_regs: pc=%h vld=%b halted=%b cnt=%0d, required pc=2a vld=1 halted=0 cnt=3",
                     pcout, if_valid, halted, stall_cnt);
        end
        clk_edge();
    endtask

    task automatic test_halt_reset();
        run_to(12);
        drive(0, 0, 1, 6'd0);
        checks++;
        if ({pc_hold, flush_ifid} !== 2'b11) begin
            errors++;
            $display("FAIL halt_ctrl: hold,ifid=%b, required 11", {pc_hold, flush_ifid});
        end
        clk_edge();
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'b1, 1'($urandom), 6'($urandom));
            checks++;
            if ({pcout, if_valid, halted, pc_hold, flush_ifid} !== {6'd12, 4'b0111}) begin
                errors++;
                $display("FAIL halt_hold[%0d]: pc=%0d vld=%b halted=%b hold=%b ifid=%b, required 12 0 1 1 1",
                         i, pcout, if_valid, halted, pc_hold, flush_ifid);
            end
            clk_edge();
        end
        drive(0, 0, 0, 6'd0);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({pcout, if_valid, halted} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: pc=%0d vld=%b halted=%b, required 0 0 0", pcout, if_valid, halted);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 0, 6'h15);
        checks++;
        if ({pc_hold, flush_ifid, flush_idex, pcout} !== {3'b111, 6'd0}) begin
            errors++;
            $display("FAIL post_reset_flush: ctrl=%b pc=%0d, required 111 0", {pc_hold, flush_ifid, flush_idex}, pcout);
        end
        clk_edge();
    endtask

    task automatic test_saturation();
        reset_dut();
        run_to(3);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 6'd0);
            checks++;
            if ({pcout, stall_cnt} !== {6'd3, 4'((i > 15) ? 15 : i)}) begin
                errors++;
                $display("FAIL saturate[%0d]: pc=%0d cnt=%0d, required pc=3 cnt=%0d",
                         i, pcout, stall_cnt, (i > 15) ? 15 : i);
            end
            clk_edge();
        end
        drive(0, 0, 0, 6'd0);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL saturate_end: cnt=%0d, required 15", stall_cnt);
        end
        clk_edge();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_dut();
            end
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 39) == 0, 6'($urandom));
            checks++;
            if ({pc_hold, flush_ifid, flush_idex} !== exp_comb()) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got %b, required %b", i,
                         {pc_hold, flush_ifid, flush_idex}, exp_comb());
            end
            checks++;
            if ({pcout, if_valid, halted, stall_cnt} !== exp_regs()) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got %h, required %h", i,
                         {pcout, if_valid, halted, stall_cnt}, exp_regs());
            end
            clk_edge();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_flush_release();
        test_wrap();
        test_stall();
        test_branch_priority();
        test_halt_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
